// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the PC, issues single-outstanding
//               word fetches, captures responses into the IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        misalign_fault
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [31:0] c_RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;
    logic        r_misalign;

    logic w_req_valid;
    logic w_req_fire;
    logic w_id_load;
    logic w_id_drain;

    // Only request when IF/ID is empty or draining, so a response always has room.
    assign w_req_valid = !rst && (r_state == S_REQ) && (!r_id_valid || id_ready);
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_id_load   = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_id_drain  = r_id_valid && id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= c_RESET_PC_ALIGNED;
            r_fetch_pc    <= 32'd0;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= 32'd0;
            r_id_pc_plus4 <= 32'd4;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (|redirect_pc[1:0]);

            if (w_req_fire) begin
                r_fetch_pc <= r_pc;
            end

            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase

            if (w_id_load) begin
                r_id_valid    <= 1'b1;
                r_id_instr    <= imem_rsp_data;
                r_id_pc       <= r_fetch_pc;
                r_id_pc_plus4 <= r_fetch_pc + 32'd4;
            end else if (w_id_drain) begin
                r_id_valid <= 1'b0;
                r_id_instr <= NOP_INSTR;
            end

            // Redirect overrides everything; any request still in flight becomes wrong-path.
            if (redirect_valid) begin
                r_pc       <= {redirect_pc[31:2], 2'b00};
                r_id_valid <= 1'b0;
                r_id_instr <= NOP_INSTR;
                if (r_state == S_REQ) begin
                    r_state <= w_req_fire ? S_DROP : S_REQ;
                end else begin
                    r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                end
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign id_valid       = r_id_valid;
    assign id_instr       = r_id_instr;
    assign id_pc          = r_id_pc;
    assign id_pc_plus4    = r_id_pc_plus4;
    assign misalign_fault = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Randomized bench for fetch_stage against an in-flight-queue
//               reference model with a variable-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_fault;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (c_RESET_PC),
        .NOP_INSTR (c_NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .misalign_fault (misalign_fault)
    );

    typedef struct {
        logic [31:0] addr;
        bit          live;
    } flight_t;

    flight_t     r_q[$];
    logic [31:0] m_pc, m_instr, m_idpc;
    bit          m_idv, m_fault;
    int          n_cmp = 0;
    int          n_err = 0;

    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = c_RESET_PC;
        r_q.delete();
        m_idv    = 1'b0;
        m_instr  = c_NOP;
        m_idpc   = 32'd0;
        m_fault  = 1'b0;
        mem_busy = 1'b0;
        mem_wait = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_id_valid",  {31'd0, id_valid}, 32'd0);
        check("rst_id_instr",  id_instr, c_NOP);
        check("rst_id_pc",     id_pc, 32'd0);
        check("rst_id_pc4",    id_pc_plus4, 32'd4);
        check("rst_fault",     {31'd0, misalign_fault}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        check_reset_outputs();
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare against model, advance model and memory.
    task automatic cycle(input bit ready, input bit idr, input bit redir,
                         input logic [31:0] tgt, input int k);
        bit          expv, fire, rsp, load, dut_fire;
        logic [31:0] dut_addr;
        flight_t     f;
        @(negedge clk);
        imem_req_ready = ready;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = tgt;
        rsp            = mem_busy && (mem_wait <= 1);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
        #1;
        expv = (r_q.size() == 0) && (!m_idv || idr);
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, expv});
        if (expv) check("req_addr", imem_req_addr, m_pc);
        check("id_valid",  {31'd0, id_valid}, {31'd0, m_idv});
        check("id_instr",  id_instr, m_instr);
        if (m_idv) begin
            check("id_pc",  id_pc, m_idpc);
            check("id_pc4", id_pc_plus4, m_idpc + 32'd4);
        end
        check("fault", {31'd0, misalign_fault}, {31'd0, m_fault});

        fire = expv && ready;
        load = 1'b0;
        if (rsp && r_q.size() > 0) begin
            f = r_q.pop_front();
            if (f.live && !redir) begin
                load    = 1'b1;
                m_idv   = 1'b1;
                m_instr = imem_rsp_data;
                m_idpc  = f.addr;
            end
        end
        if (!load && m_idv && idr) begin
            m_idv   = 1'b0;
            m_instr = c_NOP;
        end
        if (fire) begin
            r_q.push_back('{m_pc, 1'b1});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            m_pc    = {tgt[31:2], 2'b00};
            m_idv   = 1'b0;
            m_instr = c_NOP;
            foreach (r_q[i]) r_q[i].live = 1'b0;
        end
        m_fault = redir && (tgt[1:0] != 2'b00);

        dut_fire = imem_req_valid && ready;
        dut_addr = imem_req_addr;
        @(posedge clk);
        if (rsp) mem_busy = 1'b0;
        else if (mem_busy) mem_wait--;
        if (dut_fire) begin
            mem_busy = 1'b1;
            mem_wait = k;
            mem_addr = dut_addr;
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0200;
            1:       return 32'h0000_0203;
            2:       return 32'hFFFF_FFFC;
            3:       return 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic rnd(input int n, input int pr, input int kmax, input int pid, input int predir);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(0, 99) < pr, $urandom_range(0, 99) < pid,
                  $urandom_range(0, 99) < predir, pick_target(), $urandom_range(1, kmax));
        end
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b0;
        model_reset();
        do_reset();

        // Zero-wait streaming from RESET_PC.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);
        // Back-pressure with IF/ID full, then release.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);
        // Redirect while waiting on a slow response.
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 3);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200, 3);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);
        // Redirect coincident with a response, then a misaligned target.
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);
        // PC wrap at the top of the address space.
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);

        rnd(600, 70, 4, 70, 8);
        rnd(400, 100, 1, 100, 3);
        rnd(400, 40, 5, 30, 15);
        do_reset();
        rnd(600, 80, 3, 60, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
